// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM controller: cycle-type encoding and
// the helper that sizes the multiplexed row/column address pins.
package dram_pkg;

  // Cycle type. Bit 0 marks a read and bit 1 a write; both clear means refresh.
  localparam logic [1:0] ST_RFSH = 2'b00;
  localparam logic [1:0] ST_RD   = 2'b01;
  localparam logic [1:0] ST_WR   = 2'b10;

  // The ra pins carry the row and then the column, so they need the wider of the two.
  function automatic int ra_width(input int row_w, input int col_w);
    return (row_w > col_w) ? row_w : col_w;
  endfunction

endpackage

// File: rtl/dram_rfsh_rr.sv
// Round-robin refresh bank pointer. Steps 0..NBANK-1 and wraps to 0,
// advancing once for each refresh cycle.
module dram_rfsh_rr #(
  parameter int NBANK = 2,
  parameter int BWX   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           adv,
  output logic [BWX-1:0] rbank
);

  // Advance after the refresh RAS has been issued, wrapping at the last bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rbank <= '0;
    else if (adv)
      rbank <= (rbank == BWX'(NBANK - 1)) ? '0 : rbank + 1'b1;
  end

endmodule

// File: rtl/dram_mc.sv
// Four-phase asynchronous DRAM controller. Each memory cycle spans the
// c0..c3 phase strobes. At c3 the next cycle is chosen: a read, a write,
// or a CAS-before-RAS refresh when there is no enabled request.
// Optional feature: define DRAM_RDCAP_EN to register read data at c2;
// without it rddata follows dram_rd combinationally.
module dram_mc
  import dram_pkg::*;
#(
  parameter int ROW_W = 10,
  parameter int COL_W = 10,
  parameter int DW    = 16,
  parameter int NBANK = 2,
  localparam int NCAS = DW / 8,
  localparam int BW   = $clog2(NBANK),
  localparam int RAW  = ra_width(ROW_W, COL_W),
  localparam int AW   = BW + ROW_W + COL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c0,
  input  logic             c1,
  input  logic             c2,
  input  logic             c3,
  input  logic             en,
  input  logic             req,
  input  logic [AW-1:0]    addr,
  input  logic             rnw,
  input  logic [DW-1:0]    wrdata,
  input  logic [NCAS-1:0]  bsel,
  output logic             ack,
  output logic [DW-1:0]    rddata,
  output logic             rd_stb,
  input  logic [DW-1:0]    dram_rd,
  output logic [RAW-1:0]   ra,
  output logic [DW-1:0]    dram_wd,
  output logic             rwe_n,
  output logic [NCAS-1:0]  cas_n,
  output logic [NBANK-1:0] ras_n
);

  // Bank index width; a single-bank build still carries a 1-bit index tied to 0.
  localparam int BWX = (BW > 0) ? BW : 1;

  logic [1:0]       en_s;
  logic [1:0]       state;
  logic [1:0]       next_st;
  logic             started;
  logic             int_req;
  logic             is_acc;
  logic [AW-1:0]    addr_q;
  logic [NCAS-1:0]  bsel_q;
  logic [BWX-1:0]   bank;
  logic [BWX-1:0]   rbank;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [NBANK-1:0] bank_dec;
  logic [NBANK-1:0] rbank_dec;
  logic             rfsh_adv;

  assign int_req = req & en_s[1];
  assign is_acc  = state[0] | state[1];
  assign row     = addr_q[BW +: ROW_W];
  assign col     = addr_q[BW + ROW_W +: COL_W];

  if (BW > 0) begin : g_bank
    assign bank = addr_q[BW-1:0];
  end else begin : g_nobank
    assign bank = '0;
  end

  // en comes from another reset/clock context, so bring it in through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_s <= 2'b00;
    else        en_s <= {en_s[0], en};
  end

  // Next-cycle choice: an enabled request wins, otherwise refresh.
  always_comb begin
    next_st = ST_RFSH;
    if (int_req) next_st = rnw ? ST_RD : ST_WR;
  end

  // Active-low RAS selects for the access bank and the refresh bank.
  always_comb begin
    bank_dec  = '1;
    rbank_dec = '1;
    for (int i = 0; i < NBANK; i++) begin
      bank_dec[i]  = (bank  != BWX'(i));
      rbank_dec[i] = (rbank != BWX'(i));
    end
  end

  // Cycle decision at c3: latch the request and pulse ack. Strobes stay idle
  // until the first decision after reset so no partial cycle reaches the DRAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RFSH;
      started <= 1'b0;
      ack     <= 1'b0;
      addr_q  <= '0;
      bsel_q  <= '0;
    end else begin
      ack <= c3 & int_req;
      if (c3) begin
        state   <= next_st;
        started <= 1'b1;
        addr_q  <= addr;
        bsel_q  <= bsel;
      end
    end
  end

  // DRAM strobe sequencing. Accesses run RAS then CAS; refresh runs CAS then RAS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_n   <= '1;
      cas_n   <= '1;
      rwe_n   <= 1'b1;
      dram_wd <= '0;
    end else if (started) begin
      if (c0) begin
        rwe_n <= (state != ST_WR);
        if (state == ST_WR) dram_wd <= wrdata;
        if (is_acc) ras_n <= bank_dec;
        else        cas_n <= '0;
      end
      if (c1) begin
        if (is_acc) cas_n <= (state == ST_RD) ? '0 : ~bsel_q;
        else        ras_n <= rbank_dec;
      end
      if (c2) begin
        if (is_acc) ras_n <= '1;
        else        cas_n <= '1;
      end
      if (c3) begin
        ras_n <= '1;
        cas_n <= '1;
      end
    end
  end

  // The refresh pointer moves on at c2, once the refresh RAS has used it.
  assign rfsh_adv = started & c2 & (state == ST_RFSH);

  dram_rfsh_rr #(
    .NBANK (NBANK),
    .BWX   (BWX)
  ) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (rfsh_adv),
    .rbank (rbank)
  );

  // Row goes out during c0, ahead of the RAS edge; column otherwise, ahead of CAS.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) ra <= '0;
    else        ra <= c0 ? RAW'(row) : RAW'(col);
  end

  // Read strobe is high for the clk after c2 of a read cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_stb <= 1'b0;
    else        rd_stb <= started & c2 & (state == ST_RD);
  end

`ifdef DRAM_RDCAP_EN
  logic [DW-1:0] rd_q;

  // Sample the DRAM data pins at c2 of a read and hold until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  rd_q <= '0;
    else if (started & c2 & (state == ST_RD))    rd_q <= dram_rd;
  end

  assign rddata = rd_q;
`else
  assign rddata = dram_rd;
`endif

endmodule

// File: tb/tb_dram_mc.sv
// Directed bench for dram_mc (NBANK = 4). A monitor walks each 4-phase
// cycle, popping expected accesses from a scoreboard queue on ack and
// modelling the refresh bank order on its own.
module tb_dram_mc;

  localparam int ROW_W = 10;
  localparam int COL_W = 10;
  localparam int DW    = 16;
  localparam int NB    = 4;
  localparam int AW    = 2 + ROW_W + COL_W;

  typedef struct {
    logic        rnw;
    logic [1:0]  bank;
    logic [9:0]  row;
    logic [9:0]  col;
    logic [15:0] wd;
    logic [1:0]  bsel;
    logic [15:0] rdata;
  } acc_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    ph = 2'd0;
  logic          c0, c1, c2, c3;
  logic          en, req, rnw;
  logic [AW-1:0] addr;
  logic [15:0]   wrdata;
  logic [1:0]    bsel;
  logic          ack, rd_stb, rwe_n;
  logic [15:0]   rddata, dram_wd, dram_rd;
  logic [15:0]   dram_rd_drv = 16'h0000;
  logic [9:0]    ra;
  logic [1:0]    cas_n;
  logic [3:0]    ras_n;

  acc_t exp_q[$];
  acc_t cur;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   ack_cnt = 0;
  int   n_rf = 0;
  int   kind = 0;
  logic [1:0]  rr_exp = 2'd0;
  logic [15:0] last_rd = 16'h0000;
  logic        mon_on = 1'b0;

  assign c0 = (ph == 2'd0);
  assign c1 = (ph == 2'd1);
  assign c2 = (ph == 2'd2);
  assign c3 = (ph == 2'd3);
  assign dram_rd = dram_rd_drv;

  always #5 clk = ~clk;

  // Free-running phase strobes and cycle counter.
  always @(posedge clk) begin
    ph  <= ph + 2'd1;
    cyc <= cyc + 1;
  end

  dram_mc #(.ROW_W(ROW_W), .COL_W(COL_W), .DW(DW), .NBANK(NB)) dut (
    .clk(clk), .rst_n(rst_n), .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .en(en), .req(req), .addr(addr), .rnw(rnw), .wrdata(wrdata), .bsel(bsel),
    .ack(ack), .rddata(rddata), .rd_stb(rd_stb), .dram_rd(dram_rd),
    .ra(ra), .dram_wd(dram_wd), .rwe_n(rwe_n), .cas_n(cas_n), .ras_n(ras_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  // Stops at the negedge of the next cycle whose strobe is c<p>.
  task automatic wait_ph(input logic [1:0] p);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ph == p) break;
    end
  endtask

  task automatic wait_ack(output int t);
    logic found;
    found = 1'b0;
    t = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        found = 1'b1;
        t = cyc;
        break;
      end
    end
    chk("ack_seen", 32'(found), 32'd1);
  endtask

  task automatic issue(input logic r, input logic [1:0] b, input logic [9:0] rw,
                       input logic [9:0] cl, input logic [15:0] wd,
                       input logic [1:0] bs, input logic [15:0] rd, output int t);
    acc_t e;
    wait_ph(2'd2);
    rnw = r; addr = {cl, rw, b}; wrdata = wd; bsel = bs; req = 1'b1;
    e = '{r, b, rw, cl, wd, bs, rd};
    exp_q.push_back(e);
    wait_ack(t);
  endtask

  // Per-phase pin checks; cycle type is taken from ack at the c0 sample.
  always @(posedge clk) begin
    #1;
    if (!mon_on) begin
      kind = 0;
      exp_q.delete();
      if (!rst_n) rr_exp = 2'd0;
    end else begin
      case (ph)
        2'd0: begin
          chk("idle_ras", 32'(ras_n), 32'hF);
          chk("idle_cas", 32'(cas_n), 32'h3);
          chk("stb_low", 32'(rd_stb), 32'd0);
          if (ack === 1'b1) begin
            ack_cnt++;
            chk("ack_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              cur = exp_q.pop_front();
              kind = 1;
              dram_rd_drv = cur.rdata;
            end else kind = 0;
          end else kind = 2;
        end
        2'd1: begin
          if (kind == 1) begin
            chk("acc_ras", 32'(ras_n), 32'(4'(~(4'b0001 << cur.bank))));
            chk("acc_row", 32'(ra), 32'(cur.row));
            chk("acc_rwe", 32'(rwe_n), 32'(cur.rnw));
            chk("acc_cas_hi", 32'(cas_n), 32'h3);
            if (!cur.rnw) chk("acc_wd", 32'(dram_wd), 32'(cur.wd));
          end else if (kind == 2) begin
            chk("rf_cas_first", 32'(cas_n), 32'h0);
            chk("rf_ras_hi", 32'(ras_n), 32'hF);
          end
        end
        2'd2: begin
          if (kind == 1) begin
            chk("acc_cas", 32'(cas_n), cur.rnw ? 32'h0 : 32'(2'(~cur.bsel)));
            chk("acc_col", 32'(ra), 32'(cur.col));
          end else if (kind == 2) begin
            chk("rf_ras", 32'(ras_n), 32'(4'(~(4'b0001 << rr_exp))));
            chk("rf_cas", 32'(cas_n), 32'h0);
            rr_exp = rr_exp + 2'd1;
            n_rf++;
          end
        end
        default: begin
          if (kind == 1) begin
            chk("acc_ras_off", 32'(ras_n), 32'hF);
            chk("acc_stb", 32'(rd_stb), 32'(cur.rnw));
            if (cur.rnw) begin
              chk("acc_rddata", 32'(rddata), 32'(cur.rdata));
              last_rd = cur.rdata;
              dram_rd_drv = ~cur.rdata;
            end
          end else if (kind == 2) begin
            chk("rf_stb", 32'(rd_stb), 32'd0);
          end
        end
      endcase
    end
  end

  initial begin
    int t1, t2, a0, r0, n3;
    logic seen;
    rst_n = 1'b0; en = 1'b0; req = 1'b0; rnw = 1'b0;
    addr = '0; wrdata = '0; bsel = '0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_ras", 32'(ras_n), 32'hF);
    chk("rst_cas", 32'(cas_n), 32'h3);
    chk("rst_rwe", 32'(rwe_n), 32'd1);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_stb", 32'(rd_stb), 32'd0);
    chk("rst_ra", 32'(ra), 32'd0);
    chk("rst_wd", 32'(dram_wd), 32'd0);
    chk("rst_rddata", 32'(rddata), 32'd0);

    wait_ph(2'd2); rst_n = 1'b1;
    wait_ph(2'd3); mon_on = 1'b1;
    en = 1'b1;

    // Eight idle cycles: refresh banks 0,1,2,3,0,1,2,3
    r0 = n_rf;
    repeat (32) @(negedge clk);
    chk("rf_count8", 32'(n_rf - r0), 32'd8);

    // Write then read back to back with req held
    issue(1'b0, 2'd1, 10'h155, 10'h2AA, 16'hA55A, 2'b10, 16'h0000, t1);
    issue(1'b1, 2'd2, 10'h0AB, 10'h354, 16'h0000, 2'b11, 16'h1234, t2);
    chk("b2b_gap", 32'(t2 - t1), 32'd4);
    req = 1'b0;

    // Read data after several refresh cycles
    repeat (12) @(negedge clk);
`ifdef DRAM_RDCAP_EN
    chk("rd_hold", 32'(rddata), 32'(last_rd));
`else
    chk("rd_comb", 32'(rddata), 32'(dram_rd_drv));
`endif

    // A request that drops before c3 is ignored
    a0 = ack_cnt;
    wait_ph(2'd0); req = 1'b1; rnw = 1'b1;
    wait_ph(2'd2); req = 1'b0;
    repeat (8) @(negedge clk);
    chk("glitch_noack", 32'(ack_cnt - a0), 32'd0);

    // en low: requests refused, refresh continues
    en = 1'b0;
    repeat (8) @(negedge clk);
    rnw = 1'b1; addr = {10'h001, 10'h3FF, 2'd3}; req = 1'b1;
    a0 = ack_cnt; r0 = n_rf;
    repeat (16) @(negedge clk);
    chk("en0_noack", 32'(ack_cnt - a0), 32'd0);
    chk("en0_rf", 32'(n_rf - r0), 32'd4);
    wait_ph(2'd2);
    exp_q.push_back('{1'b1, 2'd3, 10'h3FF, 10'h001, 16'h0000, 2'b11, 16'hBEEF});
    en = 1'b1;
    n3 = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin seen = 1'b1; break; end
      if (ph == 2'd3) n3++;
    end
    chk("en1_ack", 32'(seen), 32'd1);
    chk("en1_c3", 32'(n3 == 2 || n3 == 3), 32'd1);
    req = 1'b0;
    repeat (8) @(negedge clk);

    // Reset during the c1 phase of a write
    issue(1'b0, 2'd0, 10'h0F0, 10'h00F, 16'h5AA5, 2'b11, 16'h0000, t1);
    req = 1'b0;
    @(negedge clk);
    chk("midwr_ras", 32'(ras_n), 32'hE);
    chk("midwr_rwe", 32'(rwe_n), 32'd0);
    mon_on = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_ras", 32'(ras_n), 32'hF);
    chk("midrst_cas", 32'(cas_n), 32'h3);
    chk("midrst_rwe", 32'(rwe_n), 32'd1);
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_wd", 32'(dram_wd), 32'd0);
    chk("midrst_ra", 32'(ra), 32'd0);
    wait_ph(2'd2); rst_n = 1'b1;
    wait_ph(2'd3); mon_on = 1'b1;

    // Clean restart: refresh from bank 0, then a read
    repeat (8) @(negedge clk);
    issue(1'b1, 2'd1, 10'h2AA, 10'h155, 16'h0000, 2'b11, 16'h4321, t1);
    req = 1'b0;
    repeat (16) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dram_mc.md
DRAM_MC -- requirements
Module: dram_mc

Interface
REQ-001 The block SHALL have parameter ROW_W, default 10, meaning row address width.
REQ-002 The block SHALL have parameter COL_W, default 10, meaning column address width; the ra pin width SHALL be the larger of ROW_W and COL_W.
REQ-003 The block SHALL have parameter DW, default 16, meaning data width; DW SHALL be 8, 16 or 32, and NCAS = DW/8.
REQ-004 The block SHALL have parameter NBANK, default 2, meaning RAS line count; NBANK SHALL be 1, 2 or 4, and BW = log2(NBANK).
REQ-005 The block SHALL have port clk, input, 1 bit: system clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have ports c0, c1, c2, c3, inputs, 1 bit each: one-hot phase strobes, exactly one high per clk, repeating c0→c3.
REQ-008 The block SHALL have port en, input, 1 bit: access enable, asynchronous to the controller's own reset.
REQ-009 The block SHALL have port req, input, 1 bit: access request.
REQ-010 The block SHALL have port addr, input, BW+ROW_W+COL_W bits: {col, row, bank}, with bank in the LSBs.
REQ-011 The block SHALL have port rnw, input, 1 bit: 1 = read, 0 = write.
REQ-012 The block SHALL have port wrdata, input, DW bits: write data.
REQ-013 The block SHALL have port bsel, input, NCAS bits: positive byte enables.
REQ-014 The block SHALL have port ack, output, 1 bit: request accepted.
REQ-015 The block SHALL have port rddata, output, DW bits: read data.
REQ-016 The block SHALL have port rd_stb, output, 1 bit: rddata valid.
REQ-017 The block SHALL have port dram_rd, input, DW bits: DRAM data pins in.
REQ-018 The block SHALL have DRAM pin outputs ra (ra width), dram_wd (DW), rwe_n (1), cas_n (NCAS), ras_n (NBANK).

Function
REQ-019 The cycle SHALL be 4 clk (c0..c3); at c3 the next state SHALL be chosen: RD if int_req & rnw, WR if int_req & !rnw, otherwise RFSH; int_req = req & en_sync.
REQ-020 ack SHALL pulse for one clk at the c3 where RD or WR is chosen, and SHALL be 0 otherwise.
REQ-021 At c3, addr and bsel SHALL be latched; at c0 of the WR cycle, wrdata SHALL be latched into dram_wd.
REQ-022 In RD/WR cycles: at c0, ras_n[bank] SHALL go 0; at c1, cas_n SHALL go 0 (RD: all lanes; WR: ~bsel); at c2, ras_n SHALL go high; at c3, all lines SHALL be high.
REQ-023 rwe_n SHALL be set at c0 to 0 for WR and 1 otherwise.
REQ-024 RFSH cycles SHALL be CAS-before-RAS: at c0, cas_n SHALL go all 0; at c1, ras_n[rbank] SHALL go 0; at c2, cas_n SHALL go high; at c3, all lines SHALL be high.
REQ-025 rbank SHALL step round-robin 0..NBANK-1 and wrap to 0, advancing once per RFSH cycle.
REQ-026 ra SHALL be updated on negedge clk: row bits during c0, column bits otherwise; the unused upper bits SHALL be 0.
REQ-027 rddata SHALL be captured per the REQ-033 mode; rd_stb SHALL pulse for one clk after the c2 of RD cycles only.
REQ-028 en SHALL be resynchronised through 2 flops (en_sync); when en = 0, only RFSH cycles SHALL occur, so DRAM contents are retained.
REQ-029 A req that falls before c3 SHALL be ignored; req held high SHALL yield back-to-back accesses with no gap.
REQ-030 A change of phase during an RD/WR cycle SHALL NOT alter an access in progress; an en drop SHALL affect only the next c3 decision.

Reset
REQ-031 On rst_n low, ras_n, cas_n and rwe_n SHALL be all 1; ack and rd_stb SHALL be 0; state SHALL be RFSH; rbank SHALL be 0; en_sync SHALL be 00; ra, dram_wd and rddata SHALL be 0.
REQ-032 On rst_n release, the first decision SHALL occur at the next c3.

Configuration
REQ-033 When DRAM_RDCAP_EN is defined, rddata SHALL be registered from dram_rd at c2 of RD cycles and held otherwise; when DRAM_RDCAP_EN is undefined, rddata SHALL equal dram_rd combinationally and rd_stb SHALL still be generated.

Structure
REQ-034 Package dram_pkg SHALL hold the state encoding (RFSH = 2'b00, RD = 2'b01, WR = 2'b10; bit dependencies are fixed) and a ra-width helper function.
REQ-035 Sub-module dram_rfsh_rr SHALL hold the round-robin refresh bank counter.

Verification
REQ-036 With en = 1, req = 1, rnw = 0, addr bank = 1, row = 0x155, col = 0x2AA, bsel = 10, wrdata = 0xA55A: ras_n[1] SHALL fall at c0, cas_n = 01 at c1, rwe_n = 0, ra = 0x155 then 0x2AA, dram_wd = 0xA55A, and ack SHALL pulse once.
REQ-037 With a RD cycle and dram_rd = 0x1234 at c2: with DRAM_RDCAP_EN, rddata SHALL be 0x1234 and rd_stb SHALL pulse once; rddata SHALL hold through the following RFSH cycles.
REQ-038 With NBANK = 4 and req = 0 for 8 cycles: ras_n SHALL go low in refresh order 0,1,2,3,0,1,2,3, each with CAS-before-RAS.
REQ-039 With en = 0 and req = 1 held: ack SHALL stay 0 and refresh SHALL continue; after en = 1, the first access SHALL occur at the 2nd or 3rd c3.
REQ-040 With rst_n asserted mid-WR at c1: all DRAM strobes SHALL go high immediately and state SHALL become RFSH; after release, the sequence SHALL restart cleanly.
